// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control and the ALU control unit.
// Opcodes, alu_op codes, FSM state encodings, select codes and the control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG_B   = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU     = 2'b00;
  localparam logic [1:0] PCSRC_ALU_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_main_control_output_decode.sv
// Pure combinational state-to-control decoder for the multicycle MIPS main control.
// MULTICYCLE_ADDI_EN adds the ADDIEX/ADDIWB decodes; otherwise codes 9/10 decode to all-zero.
module mips_ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        // IR and PC only load once the instruction word has actually arrived.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG_B;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = PCSRC_ALU_OUT;
      end
`ifdef MULTICYCLE_ADDI_EN
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
`endif
      S_JEX: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_main_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences opcode decode and mem_ready waits.
// Optional macro MULTICYCLE_ADDI_EN enables the addi path (ADDIEX -> ADDIWB).
module mips_multicycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                branch,
  output logic [1:0]          pc_src,
  output logic [1:0]          alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic [STATE_W-1:0]  state
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)            state_d = S_RTYPEEX;
        else if (opcode == OP_BEQ)              state_d = S_BEQEX;
        else if (opcode == OP_J)                state_d = S_JEX;
`ifdef MULTICYCLE_ADDI_EN
        else if (opcode == OP_ADDI)             state_d = S_ADDIEX;
`endif
        else                                    state_d = S_FETCH;
      end
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
`ifdef MULTICYCLE_ADDI_EN
      S_ADDIEX:  state_d = S_ADDIWB;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  mips_ctrl_output_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Reset must never let a write escape, whatever state the register holds.
  assign mem_write  = ctrl.mem_write & ~reset;
  assign ir_write   = ctrl.ir_write  & ~reset;
  assign pc_write   = ctrl.pc_write  & ~reset;
  assign branch     = ctrl.branch    & ~reset;
  assign reg_write  = ctrl.reg_write & ~reset;
  assign mem_read   = ctrl.mem_read;
  assign iord       = ctrl.iord;
  assign pc_src     = ctrl.pc_src;
  assign alu_op     = ctrl.alu_op;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_main_control.sv
// Bench for mips_multicycle_main_control: instruction-level model feeding an expected queue,
// checked by an independent monitor each cycle.
module tb_mips_multicycle_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_write, branch;
  logic [1:0] pc_src, alu_op, alu_src_b;
  logic       alu_src_a, reg_write, reg_dst, mem_to_reg;
  logic [3:0] state;

  localparam int W = 20;
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  mips_multicycle_main_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .branch(branch), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state)
  );

  // Expected control word for one cycle, straight from the per-state output table.
  function automatic logic [W-1:0] model(int st, bit mr, bit rst);
    logic mrd = 0, mwr = 0, io = 0, irw = 0, pcw = 0, br = 0;
    logic [1:0] psrc = 0, aop = 0, srcb = 0;
    logic srca = 0, rw = 0, rdst = 0, m2r = 0;
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; io = 1; end
      6:  begin srca = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin srca = 1; aop = 2'b01; br = 1; psrc = 2'b01; end
      9:  begin srca = 1; srcb = 2'b10; end
      10: rw = 1;
      11: begin pcw = 1; psrc = 2'b10; end
      default: ;
    endcase
    if (rst) begin mwr = 0; irw = 0; pcw = 0; br = 0; rw = 0; end
    return {4'(st), mrd, mwr, io, irw, pcw, br, psrc, aop, srca, srcb, rw, rdst, m2r};
  endfunction

  // Instruction class: 0 lw, 1 sw, 2 rtype, 3 beq, 4 j, 5 addi, 6 illegal.
  function automatic int op_class(logic [5:0] op);
    case (op)
      6'b100011: return 0;
      6'b101011: return 1;
      6'b000000: return 2;
      6'b000100: return 3;
      6'b000010: return 4;
`ifdef MULTICYCLE_ADDI_EN
      6'b001000: return 5;
`endif
      default:   return 6;
    endcase
  endfunction

  task automatic cycle(input int st, input bit mr, input bit rst, input logic [5:0] op);
    @(negedge clk);
    reset = rst;
    mem_ready = mr;
    opcode = op;
    exp_q.push_back(model(st, mr, rst));
  endtask

  task automatic mem_wait(input int st, input int waits, input logic [5:0] op);
    for (int i = 0; i < waits; i++) cycle(st, 1'b0, 1'b0, op);
    cycle(st, 1'b1, 1'b0, op);
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) cycle(0, 1'b0, 1'b0, 6'($urandom_range(0, 63)));
    cycle(0, 1'b1, 1'b0, 6'($urandom_range(0, 63)));
    cycle(1, 1'($urandom_range(0, 1)), 1'b0, op);
    case (op_class(op))
      0: begin cycle(2, 1'($urandom_range(0, 1)), 1'b0, op); mem_wait(3, mw, op);
               cycle(4, 1'($urandom_range(0, 1)), 1'b0, op); end
      1: begin cycle(2, 1'($urandom_range(0, 1)), 1'b0, op); mem_wait(5, mw, op); end
      2: begin cycle(6, 1'($urandom_range(0, 1)), 1'b0, op);
               cycle(7, 1'($urandom_range(0, 1)), 1'b0, op); end
      3: cycle(8, 1'($urandom_range(0, 1)), 1'b0, op);
      4: cycle(11, 1'($urandom_range(0, 1)), 1'b0, op);
      5: begin cycle(9, 1'($urandom_range(0, 1)), 1'b0, op);
               cycle(10, 1'($urandom_range(0, 1)), 1'b0, op); end
      default: ;
    endcase
  endtask

  // Monitor: the DUT presents a fresh control word every cycle.
  initial begin
    logic [W-1:0] e, act;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {state, mem_read, mem_write, iord, ir_write, pc_write, branch,
               pc_src, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg};
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL ctrl_word cycle %0d: got state=%0d bits=%h, expected state=%0d bits=%h",
                   cyc, act[19:16], act[15:0], e[19:16], e[15:0]);
        end
      end
      cyc++;
    end
  end

  initial begin
    logic [5:0] op;
    int k;
    reset = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'd0;
    @(negedge clk);
    // State is known after the first reset edge; check the held-reset cycle.
    cycle(0, 1'b1, 1'b1, 6'b100011);

    run_instr(6'b100011, 0, 0);   // lw, no waits
    run_instr(6'b100011, 3, 2);   // fetch held 3 cycles, memory read waits
    run_instr(6'b000000, 0, 0);   // R-type
    run_instr(6'b000100, 1, 0);   // beq
    run_instr(6'b000010, 0, 0);   // j
    run_instr(6'b111111, 0, 0);   // illegal
    run_instr(6'b001000, 0, 0);   // addi (legal only with the macro)
    run_instr(6'b101011, 0, 1);   // sw with a write wait

    // sw interrupted by reset while MEMWR waits on memory.
    cycle(0, 1'b1, 1'b0, 6'b101011);
    cycle(1, 1'b1, 1'b0, 6'b101011);
    cycle(2, 1'b0, 1'b0, 6'b101011);
    cycle(5, 1'b0, 1'b0, 6'b101011);
    cycle(5, 1'b0, 1'b1, 6'b101011);
    run_instr(6'b001000, 0, 0);

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
                 op == 6'b000100 || op == 6'b000010 || op == 6'b001000)
            op = 6'($urandom_range(0, 63));
        end
      endcase
      if ($urandom_range(0, 9) == 0) begin
        cycle(0, 1'($urandom_range(0, 1)), 1'b1, op);
      end
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    @(negedge clk);
    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
